// File: rtl/muldiv_hilo.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO pair.
// Multiplies and MTHI/MTLO retire in one cycle. Divides use a restoring
// divider that runs one step per clock and holds the pipeline through
// stall_divE until the quotient and remainder are written into LO and HI.
module muldiv_hilo #(
    parameter int         WIDTH    = 32,
    parameter logic [4:0] OP_MULT  = 5'b10000,
    parameter logic [4:0] OP_MULTU = 5'b10001,
    parameter logic [4:0] OP_DIV   = 5'b10010,
    parameter logic [4:0] OP_DIVU  = 5'b10011,
    parameter logic [4:0] OP_MTHI  = 5'b10100,
    parameter logic [4:0] OP_MTLO  = 5'b10101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validE,
    input  logic [4:0]       alucontrolE,
    input  logic             flushE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             stall_divE,
    output logic [WIDTH-1:0] hiE,
    output logic [WIDTH-1:0] loE,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's complement negation, shared by operand magnitude and sign fix-up.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic [WIDTH-1:0]   rem_q,   rem_d;   // partial remainder
    logic [WIDTH-1:0]   quo_q,   quo_d;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   dvs_q,   dvs_d;   // divisor magnitude
    logic               qneg_q,  qneg_d;
    logic               rneg_q,  rneg_d;
    logic               dz_q,    dz_d;

    logic               is_mul_s;
    logic               is_div_s;
    logic               is_mt_s;
    logic               op_go_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [2*WIDTH-1:0] mul_a_s;
    logic [2*WIDTH-1:0] mul_b_s;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;

    // Decode the E-stage operation and build the multiply and divide-step datapaths.
    always_comb begin
        is_mul_s  = (alucontrolE == OP_MULT) || (alucontrolE == OP_MULTU);
        is_div_s  = (alucontrolE == OP_DIV)  || (alucontrolE == OP_DIVU);
        is_mt_s   = (alucontrolE == OP_MTHI) || (alucontrolE == OP_MTLO);
        op_go_s   = validE & ~flushE & (is_mul_s | is_div_s | is_mt_s);
        a_neg_s   = (alucontrolE == OP_DIV) & srcaE[WIDTH-1];
        b_neg_s   = (alucontrolE == OP_DIV) & srcbE[WIDTH-1];
        // Sign- or zero-extend to 2*WIDTH so one unsigned multiplier serves both.
        mul_a_s   = {{WIDTH{(alucontrolE == OP_MULT) & srcaE[WIDTH-1]}}, srcaE};
        mul_b_s   = {{WIDTH{(alucontrolE == OP_MULT) & srcbE[WIDTH-1]}}, srcbE};
        product_s = mul_a_s * mul_b_s;
        shifted_s = {rem_q, quo_q[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, dvs_q};
    end

    // Next-state logic for the divider FSM and the HI/LO registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (op_go_s) begin
                    if (is_mul_s) begin
                        {hi_d, lo_d} = product_s;
                    end else if (alucontrolE == OP_MTHI) begin
                        hi_d = srcaE;
                    end else if (alucontrolE == OP_MTLO) begin
                        lo_d = srcaE;
                    end else begin
                        // Only divides remain: capture magnitudes and result signs.
                        quo_d   = a_neg_s ? negate(srcaE) : srcaE;
                        dvs_d   = b_neg_s ? negate(srcbE) : srcbE;
                        rem_d   = '0;
                        cnt_d   = '0;
                        qneg_d  = a_neg_s ^ b_neg_s;
                        rneg_d  = a_neg_s;
                        dz_d    = (srcbE == '0);
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (flushE) begin
                    state_d = S_IDLE;
                end else begin
                    // Restoring step: keep the trial difference only if non-negative.
                    if (diff_s[WIDTH] == 1'b0) begin
                        rem_d = diff_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FIX: begin
                if (flushE) begin
                    state_d = S_IDLE;
                end else begin
                    // A zero divisor leaves quotient all ones and remainder equal to
                    // the dividend magnitude; re-applying the dividend sign restores
                    // the raw dividend, so only the quotient negation is skipped.
                    if (dz_q) begin
                        lo_d = {WIDTH{1'b1}};
                    end else begin
                        lo_d = qneg_q ? negate(quo_q) : quo_q;
                    end
                    hi_d    = rneg_q ? negate(rem_q) : rem_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // The divide leaves E on this edge; never restart from its opcode.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and HI/LO registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    // Stall must rise in the issue cycle itself, so it is decoded combinationally.
    always_comb begin
        stall_divE = rst & (((state_q == S_IDLE) & op_go_s & is_div_s) |
                            (state_q == S_RUN) | (state_q == S_FIX));
        busy       = (state_q != S_IDLE);
        hiE        = hi_q;
        loE        = lo_q;
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Randomized self-checking bench for muldiv_hilo against an arithmetic model.
module tb_muldiv_hilo;

    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MTHI  = 5'b10100;
    localparam logic [4:0] OP_MTLO  = 5'b10101;

    logic        clk = 1'b0;
    logic        rst;
    logic        validE;
    logic [4:0]  alucontrolE;
    logic        flushE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        stall_divE;
    logic [31:0] hiE;
    logic [31:0] loE;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    muldiv_hilo dut (
        .clk         (clk),
        .rst         (rst),
        .validE      (validE),
        .alucontrolE (alucontrolE),
        .flushE      (flushE),
        .srcaE       (srcaE),
        .srcbE       (srcbE),
        .stall_divE  (stall_divE),
        .hiE         (hiE),
        .loE         (loE),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Architectural effect of one operation on HI/LO, from plain arithmetic.
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            OP_MULTU: begin
                p = 64'(a) * 64'(b);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    exp_lo = 32'h8000_0000;
                    exp_hi = 32'd0;
                end else if (op == OP_DIV) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            OP_MTHI: exp_hi = a;
            OP_MTLO: exp_lo = a;
            default: begin end
        endcase
    endtask

    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        validE = 1'b1; flushE = 1'b0; alucontrolE = op; srcaE = a; srcbE = b;
        model(op, a, b);
        #1;
        if (op == OP_DIV || op == OP_DIVU) begin
            n = 0;
            while (stall_divE === 1'b1 && n < 100) begin
                @(posedge clk); #1; n++;
            end
            chk({tag, "_stallcyc"}, 64'(n), 64'd34);
            chk({tag, "_busy_done"}, 64'(busy), 64'd1);
            chk({tag, "_hi"}, 64'(hiE), 64'(exp_hi));
            chk({tag, "_lo"}, 64'(loE), 64'(exp_lo));
            // Opcode still present across the DONE edge must not restart.
            @(posedge clk); #1;
            chk({tag, "_norestart"}, 64'(busy), 64'd0);
        end else begin
            chk({tag, "_nostall"}, 64'(stall_divE), 64'd0);
            @(posedge clk); #1;
            chk({tag, "_hi"}, 64'(hiE), 64'(exp_hi));
            chk({tag, "_lo"}, 64'(loE), 64'(exp_lo));
        end
        @(negedge clk);
        validE = 1'b0; srcaE = $urandom; srcbE = $urandom;
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;

        rst = 1'b0; validE = 1'b0; flushE = 1'b0;
        alucontrolE = 5'd0; srcaE = 32'd0; srcbE = 32'd0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        #12;
        chk("reset_hi", 64'(hiE), 64'd0);
        chk("reset_lo", 64'(loE), 64'd0);
        chk("reset_stall", 64'(stall_divE), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk); rst = 1'b1;

        // Directed cases
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        run_op("mult",  OP_MULT,  32'hFFFF_FFFD, 32'd7);
        run_op("mthi",  OP_MTHI,  32'h0000_1234, 32'd0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_z",  OP_DIVU, 32'd100, 32'd0);
        run_op("div_z",   OP_DIV,  32'hFFFF_FF00, 32'd0);
        run_op("div_ovf", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);

        // Randomized single-cycle operations
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_MULT;
                1:       op = OP_MULTU;
                2:       op = OP_MTHI;
                default: op = OP_MTLO;
            endcase
            a = $urandom; b = $urandom;
            run_op($sformatf("rnd_mul%0d", i), op, a, b);
        end

        // Randomized divides, including zero and small divisors
        for (int i = 0; i < 8; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
            a  = $urandom;
            case (i % 3)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (i % 4 == 3) b = -b;
            run_op($sformatf("rnd_div%0d", i), op, a, b);
        end

        // Flush mid-RUN aborts and leaves HI/LO untouched
        run_op("set_hi", OP_MTHI, 32'h0000_AAAA, 32'd0);
        run_op("set_lo", OP_MTLO, 32'h0000_5555, 32'd0);
        @(negedge clk);
        validE = 1'b1; alucontrolE = OP_DIVU; srcaE = 32'd50; srcbE = 32'd7;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk); flushE = 1'b1;
        @(posedge clk); #1;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_stall", 64'(stall_divE), 64'd0);
        chk("flush_hi", 64'(hiE), 64'h0000_AAAA);
        chk("flush_lo", 64'(loE), 64'h0000_5555);
        @(negedge clk); flushE = 1'b0; validE = 1'b0;
        @(posedge clk); #1;
        chk("flush_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-divide
        @(negedge clk);
        validE = 1'b1; alucontrolE = OP_DIVU; srcaE = 32'd1000; srcbE = 32'd3;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        chk("arst_stall", 64'(stall_divE), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hi", 64'(hiE), 64'd0);
        chk("arst_lo", 64'(loE), 64'd0);
        @(negedge clk); validE = 1'b0; rst = 1'b1;
        run_op("post_rst", OP_DIVU, 32'd9, 32'd4);
        chk("post_rst_lo_const", 64'(loE), 64'd2);
        chk("post_rst_hi_const", 64'(hiE), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
